// File: rtl/llc_rst_flush_seq.sv
// ============================================================================
// Module  : llc_rst_flush_seq
// Purpose : Sequences the LLC reset-invalidate walk and the on-demand flush
//           walk, one set at a time, with a valid/ready issue and done-ack wait.
//           Optional watchdog on the ack wait: define LLC_RST_FLUSH_WATCHDOG_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module llc_rst_flush_seq #(
    parameter int SET_BITS       = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_flush,
    input  logic [SET_BITS-1:0] cur_set,
    input  logic                op_ready,
    input  logic                op_done,
    output logic                op_valid,
    output logic [SET_BITS-1:0] op_set,
    output logic                op_is_rst,
    output logic                rst_state,
    output logic                incr_rst_flush_stalled_set,
    output logic                clr_rst_flush_stalled_set,
    output logic                clr_rst_stall,
    output logic                set_flush_stall,
    output logic                clr_flush_stall,
    output logic                set_rst_to_resume_in_pipeline,
    output logic                set_flush_to_resume_in_pipeline,
    output logic                busy,
    output logic                flush_done,
    output logic                err_timeout
);

    typedef enum logic [2:0] {
        S_INIT        = 3'd0,
        S_RST_ISSUE   = 3'd1,
        S_RST_WAIT    = 3'd2,
        S_IDLE        = 3'd3,
        S_FLUSH_START = 3'd4,
        S_FLUSH_ISSUE = 3'd5,
        S_FLUSH_WAIT  = 3'd6
    } state_t;

    state_t state_q, state_d;
    logic   flush_pend_q, flush_pend_d;
    logic   w_last_set;
    logic   w_in_wait;

    assign w_last_set = (cur_set == {SET_BITS{1'b1}});
    assign w_in_wait  = (state_q == S_RST_WAIT) || (state_q == S_FLUSH_WAIT);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_INIT;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    always_comb begin
        state_d                         = state_q;
        flush_pend_d                    = flush_pend_q;
        op_valid                        = 1'b0;
        op_set                          = cur_set;
        op_is_rst                       = 1'b0;
        rst_state                       = 1'b0;
        incr_rst_flush_stalled_set      = 1'b0;
        clr_rst_flush_stalled_set       = 1'b0;
        clr_rst_stall                   = 1'b0;
        set_flush_stall                 = 1'b0;
        clr_flush_stall                 = 1'b0;
        set_rst_to_resume_in_pipeline   = 1'b0;
        set_flush_to_resume_in_pipeline = 1'b0;
        busy                            = 1'b0;
        flush_done                      = 1'b0;

        if (rst) begin
            // A flush requested before the reset walk finishes is remembered
            if (start_flush && (state_q == S_INIT || state_q == S_RST_ISSUE ||
                                state_q == S_RST_WAIT)) begin
                flush_pend_d = 1'b1;
            end

            case (state_q)
                S_INIT: begin
                    rst_state                 = 1'b1;
                    clr_rst_flush_stalled_set = 1'b1;
                    state_d                   = S_RST_ISSUE;
                end
                S_RST_ISSUE: begin
                    op_valid  = 1'b1;
                    op_is_rst = 1'b1;
                    busy      = 1'b1;
                    if (op_ready) begin
                        set_rst_to_resume_in_pipeline = 1'b1;
                        state_d                       = S_RST_WAIT;
                    end
                end
                S_RST_WAIT: begin
                    busy = 1'b1;
                    if (op_done) begin
                        if (w_last_set) begin
                            clr_rst_stall             = 1'b1;
                            clr_rst_flush_stalled_set = 1'b1;
                            state_d = (flush_pend_q || start_flush) ? S_FLUSH_START : S_IDLE;
                        end else begin
                            incr_rst_flush_stalled_set = 1'b1;
                            state_d                    = S_RST_ISSUE;
                        end
                    end
                end
                S_IDLE: begin
                    if (start_flush || flush_pend_q) begin
                        state_d = S_FLUSH_START;
                    end
                end
                S_FLUSH_START: begin
                    set_flush_stall = 1'b1;
                    busy            = 1'b1;
                    flush_pend_d    = 1'b0;
                    state_d         = S_FLUSH_ISSUE;
                end
                S_FLUSH_ISSUE: begin
                    op_valid = 1'b1;
                    busy     = 1'b1;
                    if (op_ready) begin
                        set_flush_to_resume_in_pipeline = 1'b1;
                        state_d                         = S_FLUSH_WAIT;
                    end
                end
                S_FLUSH_WAIT: begin
                    busy = 1'b1;
                    if (op_done) begin
                        if (w_last_set) begin
                            clr_flush_stall           = 1'b1;
                            clr_rst_flush_stalled_set = 1'b1;
                            flush_done                = 1'b1;
                            state_d                   = S_IDLE;
                        end else begin
                            incr_rst_flush_stalled_set = 1'b1;
                            state_d                    = S_FLUSH_ISSUE;
                        end
                    end
                end
                default: state_d = S_INIT;
            endcase
        end
    end

`ifdef LLC_RST_FLUSH_WATCHDOG_EN
    localparam int              WD_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);

    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            err_q, err_d;

    // Leaving a wait state always coincides with op_done, so one clear covers both
    always_comb begin
        wd_cnt_d = '0;
        if (w_in_wait && !op_done) begin
            wd_cnt_d = (wd_cnt_q == WD_LIMIT) ? wd_cnt_q : wd_cnt_q + 1'b1;
        end
        err_d = err_q | (wd_cnt_d == WD_LIMIT);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wd_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            err_q    <= err_d;
        end
    end

    assign err_timeout = rst & err_q;
`else
    // Watchdog compiled out; the limit parameter stays for interface compatibility
    assign err_timeout = w_in_wait & (TIMEOUT_CYCLES < 0);
`endif

endmodule

`default_nettype wire
